audio_mix_seq: RTL

Time-multiplexed stereo audio mixer sequencer. On each sample tick it snapshots the ULA beeper bits and all PSG, Specdrum and SAA channel levels. It then steps one shared 11-bit saturating adder through the left and right term lists and publishes registered `laudio`/`raudio` words with a one-cycle `valid` strobe. It sits between the sound sources and the DAC/I2S serializer and replaces the purely combinational mixer sum.

---
 rtl/audio_mix_seq.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/audio_mix_seq.sv
// Time-multiplexed stereo mixer: one 11-bit saturating adder walks both term lists; output 2N+1 clocks after tick.
// tick accepted only in IDLE, otherwise dropped and flagged in sticky overrun; define AUDIO_MIX_SAA_EN to add SAA terms.
module audio_mix_seq (
  input  logic        clock,
  input  logic        reset,
  input  logic        tick,
  input  logic        mic,
  input  logic        ear,
  input  logic        speaker,
  input  logic [7:0]  a1,
  input  logic [7:0]  b1,
  input  logic [7:0]  c1,
  input  logic [7:0]  a2,
  input  logic [7:0]  b2,
  input  logic [7:0]  c2,
  input  logic [7:0]  spd,
  input  logic [7:0]  saaL,
  input  logic [7:0]  saaR,
  output logic [10:0] laudio,
  output logic [10:0] raudio,
  output logic        valid,
  output logic        busy,
  output logic        sat,
  output logic        overrun
);

`ifdef AUDIO_MIX_SAA_EN
  localparam int N = 7;
`else
  localparam int N = 6;
`endif
  localparam logic [3:0] LAST_L = 4'(N - 1);
  localparam logic [3:0] LAST_R = 4'(2 * N - 1);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  step;
  logic [7:0]  ula_lvl, ula_q;
  logic [7:0]  a1_q, b1_q, c1_q, a2_q, b2_q, c2_q, spd_q;
  logic [11:0] acc, lsum, term, sum;
  logic        is_right;
  logic [3:0]  idx;

`ifdef AUDIO_MIX_SAA_EN
  logic [7:0]  saal_q, saar_q;
`else
  logic        unused_saa;
  assign unused_saa = ^{saaL, saaR};
`endif

  function automatic logic [11:0] x1(input logic [7:0] v);
    return {4'b0, v};
  endfunction

  function automatic logic [11:0] x2(input logic [7:0] v);
    return {3'b0, v, 1'b0};
  endfunction

  function automatic logic [10:0] clip(input logic [11:0] v);
    return v[11] ? 11'h7FF : v[10:0];
  endfunction

  always_comb begin
    ula_lvl = 8'h00;
    case ({speaker, ear, mic})
      3'd0: ula_lvl = 8'h00;
      3'd1: ula_lvl = 8'h24;
      3'd2: ula_lvl = 8'h40;
      3'd3: ula_lvl = 8'h64;
      3'd4: ula_lvl = 8'hB8;
      3'd5: ula_lvl = 8'hC0;
      3'd6: ula_lvl = 8'hF8;
      default: ula_lvl = 8'hFF;
    endcase
  end

  // Both lists share positions; only the a/c and saaL/saaR slots differ by side.
  always_comb begin
    is_right = (step > LAST_L);
    idx      = is_right ? (step - 4'(N)) : step;
    term     = 12'd0;
    case (idx)
      4'd0: term = x1(ula_q);
      4'd1: term = is_right ? x2(c1_q) : x2(a1_q);
      4'd2: term = is_right ? x2(c2_q) : x2(a2_q);
      4'd3: term = x1(b1_q);
      4'd4: term = x1(b2_q);
      4'd5: term = x2(spd_q);
`ifdef AUDIO_MIX_SAA_EN
      4'd6: term = is_right ? x2(saar_q) : x2(saal_q);
`endif
      default: term = 12'd0;
    endcase
  end

  assign sum  = acc + term;
  assign busy = (state != IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (tick) state_nxt = ACC;
      ACC:     if (step == LAST_R) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      step    <= 4'd0;
      acc     <= 12'd0;
      lsum    <= 12'd0;
      ula_q   <= 8'd0;
      a1_q    <= 8'd0;
      b1_q    <= 8'd0;
      c1_q    <= 8'd0;
      a2_q    <= 8'd0;
      b2_q    <= 8'd0;
      c2_q    <= 8'd0;
      spd_q   <= 8'd0;
`ifdef AUDIO_MIX_SAA_EN
      saal_q  <= 8'd0;
      saar_q  <= 8'd0;
`endif
      laudio  <= 11'd0;
      raudio  <= 11'd0;
      valid   <= 1'b0;
      sat     <= 1'b0;
      overrun <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (tick && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (tick) begin
            ula_q  <= ula_lvl;
            a1_q   <= a1;
            b1_q   <= b1;
            c1_q   <= c1;
            a2_q   <= a2;
            b2_q   <= b2;
            c2_q   <= c2;
            spd_q  <= spd;
`ifdef AUDIO_MIX_SAA_EN
            saal_q <= saaL;
            saar_q <= saaR;
`endif
            acc    <= 12'd0;
            step   <= 4'd0;
          end
        end
        ACC: begin
          step <= step + 4'd1;
          if (step == LAST_L) begin
            lsum <= sum;
            acc  <= 12'd0;
          end else begin
            acc  <= sum;
          end
        end
        DONE: begin
          // acc still holds the completed right-channel sum here.
          laudio <= clip(lsum);
          raudio <= clip(acc);
          sat    <= lsum[11] | acc[11];
          valid  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
